// File: rtl/y_capture_serializer.sv
// Snapshots the wide state bus y_in on a sample strobe, then streams it LSB-chunk-first over valid/ready.
// Optional Y_CAPTURE_SIG_EN appends one XOR-signature chunk per frame.
module y_capture_serializer #(
  parameter int DATA_W  = 295,
  parameter int CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  y_in,
  input  logic               sample,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CHUNK_W-1:0] m_data,
  output logic               m_last,
  output logic               busy,
  output logic               overrun
);
  localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W  = NCHUNK * CHUNK_W;
  localparam int IDX_W  = $clog2(NCHUNK + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

`ifdef Y_CAPTURE_SIG_EN
  typedef enum logic [1:0] {IDLE, SEND, SIG} state_t;
  localparam bit LAST_ON_DATA = 1'b0;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
  localparam bit LAST_ON_DATA = 1'b1;
`endif

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shadow_q, shadow_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               m_valid_q, m_valid_d;
  logic [CHUNK_W-1:0] m_data_q, m_data_d;
  logic               m_last_q, m_last_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
`ifdef Y_CAPTURE_SIG_EN
  logic [CHUNK_W-1:0] sig_q, sig_d;
`endif
  logic xfer, frame_end, capture;

  // Zero-padded view so the final partial chunk reads 0 above DATA_W-1.
  function automatic logic [CHUNK_W-1:0] chunk_of(input logic [PAD_W-1:0] p,
                                                  input logic [IDX_W-1:0] i);
    return p[i*CHUNK_W +: CHUNK_W];
  endfunction

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
`ifdef Y_CAPTURE_SIG_EN
    sig_d     = sig_q;
`endif
    xfer = m_valid_q && m_ready;
`ifdef Y_CAPTURE_SIG_EN
    frame_end = xfer && (state_q == SIG);
`else
    frame_end = xfer && (state_q == SEND) && (idx_q == LAST_IDX);
`endif
    capture = sample && ((state_q == IDLE) || frame_end);
    if (sample && !capture) overrun_d = 1'b1;

    if (capture) begin
      state_d   = SEND;
      shadow_d  = y_in;
      idx_d     = '0;
      m_valid_d = 1'b1;
      busy_d    = 1'b1;
      m_data_d  = chunk_of(PAD_W'(y_in), '0);
      m_last_d  = LAST_ON_DATA && (LAST_IDX == '0);
`ifdef Y_CAPTURE_SIG_EN
      sig_d     = '0;
`endif
    end else if (frame_end) begin
      state_d   = IDLE;
      m_valid_d = 1'b0;
      busy_d    = 1'b0;
      m_last_d  = 1'b0;
      m_data_d  = '0;
    end else if (xfer) begin
`ifdef Y_CAPTURE_SIG_EN
      sig_d = sig_q ^ m_data_q;
      if (idx_q == LAST_IDX) begin
        state_d  = SIG;
        m_data_d = sig_q ^ m_data_q;
        m_last_d = 1'b1;
      end else
`endif
      begin
        idx_d    = idx_q + 1'b1;
        m_data_d = chunk_of(PAD_W'(shadow_q), idx_q + 1'b1);
        m_last_d = LAST_ON_DATA && ((idx_q + 1'b1) == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef Y_CAPTURE_SIG_EN
      sig_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef Y_CAPTURE_SIG_EN
      sig_q     <= sig_d;
`endif
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_y_capture_serializer.sv
// Scoreboard bench for y_capture_serializer: stimulus pushes hand-computed chunks, a monitor pops on valid.
module tb_y_capture_serializer;
  localparam int DATA_W = 295, CHUNK_W = 8, NCHUNK = 37;
`ifdef Y_CAPTURE_SIG_EN
  localparam bit SIG = 1'b1;
`else
  localparam bit SIG = 1'b0;
`endif
  localparam int FLEN = NCHUNK + (SIG ? 1 : 0);

  logic clk = 1'b0, rst, sample, m_valid, m_ready, m_last, busy, overrun;
  logic [DATA_W-1:0]  y_in;
  logic [CHUNK_W-1:0] m_data;

  y_capture_serializer #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .sample(sample), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t sb[$];
  int vecs = 0, errs = 0, xfers = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_data(input int i, input logic [7:0] d);
    exp_t e;
    e.d = d;
    e.l = !SIG && (i == NCHUNK - 1);
    sb.push_back(e);
  endtask

  task automatic push_sig(input logic [7:0] s);
    exp_t e;
    e.d = s;
    e.l = 1'b1;
    if (SIG) sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern();
    for (int i = 0; i < 36; i++) y_in[i*8 +: 8] = 8'(i);
    y_in[294:288] = 7'd36;
  endtask

  // Pattern frame: chunk i = i; XOR of 0..36 = 0x24.
  task automatic push_pattern();
    for (int i = 0; i < NCHUNK; i++) push_data(i, 8'(i));
    push_sig(8'h24);
  endtask

  task automatic push_zeros();
    for (int i = 0; i < NCHUNK; i++) push_data(i, 8'h00);
    push_sig(8'h00);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (m_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      vecs++; errs++;
      $display("FAIL %s: timeout waiting for frame end", name);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (sb.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_chunk: got %0h expected none", m_data);
      end else begin
        chk("chunk_data", 32'(m_data), 32'(sb[0].d));
        chk("chunk_last", 32'(m_last), 32'(sb[0].l));
        if (m_ready) begin
          void'(sb.pop_front());
          xfers++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, x0, cyc, n;
    bit rdy_pat[4];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; sample = 1'b0; m_ready = 1'b0; y_in = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {m_valid, busy, overrun, m_last, m_data}, 32'h0);
    end
    tick();

    // Pattern frame, ready always high
    set_pattern(); push_pattern();
    m_ready = 1'b1; sample = 1'b1; tick(); sample = 1'b0;
    @(negedge clk);
    chk("capture_latency_valid", 32'(m_valid), 32'd1);
    chk("capture_latency_busy", 32'(busy), 32'd1);
    nv = 1;
    while (m_valid && nv < 200) begin
      @(negedge clk);
      if (m_valid) nv++;
    end
    chk("frame_len", nv, FLEN);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("sb_empty_1", sb.size(), 0);
    tick();

    // All-ones frame, ready 1,0,0,1; overrun sample with y_in=0 in frame cycle 5
    y_in = '1;
    for (int i = 0; i < NCHUNK; i++) push_data(i, (i == NCHUNK - 1) ? 8'h7F : 8'hFF);
    push_sig(8'h7F);
    x0 = xfers;
    sample = 1'b1; tick(); sample = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      m_ready = rdy_pat[cyc % 4];
      sample = (cyc == 4);
      if (cyc == 4) y_in = '0;
      @(negedge clk);
      if (!m_valid) break;
      tick();
      cyc++;
    end
    sample = 1'b0; m_ready = 1'b1;
    chk("ones_xfers", xfers - x0, FLEN);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("sb_empty_2", sb.size(), 0);
    repeat (5) tick();
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset clears everything
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {m_valid, busy, overrun, m_last, m_data}, 32'h0);
    tick();

    // Back-to-back: sample on the last-chunk transfer with y_in=0
    set_pattern(); push_pattern(); push_zeros();
    x0 = xfers;
    sample = 1'b1; tick(); sample = 1'b0;
    n = 0;
    while (!(m_valid && m_last) && n < 200) begin tick(); n++; end
    sample = 1'b1; y_in = '0; tick(); sample = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 32'(m_valid), 32'd1);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    wait_idle("b2b");
    chk("b2b_xfers", xfers - x0, 2 * FLEN);
    chk("b2b_overrun_end", 32'(overrun), 32'd0);
    chk("sb_empty_3", sb.size(), 0);
    tick();

`ifdef Y_CAPTURE_SIG_EN
    // Signature of bytes 1,2,3 then zeros is 0x00
    y_in = '0; y_in[23:0] = 24'h030201;
    for (int i = 0; i < NCHUNK; i++) push_data(i, (i < 3) ? 8'(i + 1) : 8'h00);
    push_sig(8'h00);
    sample = 1'b1; tick(); sample = 1'b0;
    wait_idle("sig");
    chk("sb_empty_sig", sb.size(), 0);
    tick();
`endif

    // Reset mid-frame aborts without further chunks
    set_pattern(); push_pattern();
    x0 = xfers;
    sample = 1'b1; tick(); sample = 1'b0;
    n = 0;
    while (xfers - x0 < 10 && n < 200) begin tick(); n++; end
    rst = 1'b1; sb.delete(); tick(); rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_valid) nv++;
    end
    chk("abort_no_chunks", nv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
